// File: rtl/ascon_out_serializer.sv
// Ascon output serializer: ciphertext words and the final tag leave as a
// byte stream, MSB first, under a read_ack handshake.
// Optional macro: ASCON_OUT_SKID_EN adds a second word register (zero bubble).
module ascon_out_serializer #(
    parameter int TAG_BYTES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic [63:0]  s_tdata,
    input  logic         s_tvalid,
    output logic         s_tready,
    input  logic         s_tlast,
    input  logic [3:0]   s_tbytes,
    input  logic [127:0] tag_tdata,
    input  logic         tag_tvalid,
    output logic         tag_tready,
    output logic [7:0]   byte_out,
    output logic         out_valid,
    input  logic         read_ack,
    output logic         busy,
    output logic         tag_phase
);

    typedef enum logic [1:0] {
        IDLE,
        CT,
        WAIT_TAG,
        TAG
    } state_e;

    state_e        state_q, state_d;
    logic [127:0]  data_q, data_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          full_q, full_d;
    logic          out_valid_q, out_valid_d;
    logic          tag_phase_q, tag_phase_d;
    logic          s_tready_q, s_tready_d;
    logic          tag_tready_q, tag_tready_d;

`ifdef ASCON_OUT_SKID_EN
    logic [63:0]   skid_q, skid_d;
    logic [4:0]    skid_cnt_q, skid_cnt_d;
    logic          skid_last_q, skid_last_d;
    logic          skid_full_q, skid_full_d;
`endif

    logic          ack;
    logic          s_fire;
    logic          t_fire;
    logic [4:0]    nbytes;

    assign ack    = read_ack && out_valid_q;
    assign s_fire = s_tvalid && s_tready_q;
    assign t_fire = tag_tvalid && tag_tready_q;

    // Out-of-range byte counts mean a full word.
    assign nbytes = (s_tbytes == 4'd0 || s_tbytes > 4'd8)
                    ? 5'd8 : {1'b0, s_tbytes};

    // Next-state: word/tag loading, byte advance and state transitions.
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        full_d       = full_q;
        out_valid_d  = out_valid_q;
        tag_phase_d  = tag_phase_q;
`ifdef ASCON_OUT_SKID_EN
        skid_d       = skid_q;
        skid_cnt_d   = skid_cnt_q;
        skid_last_d  = skid_last_q;
        skid_full_d  = skid_full_q;
`endif
        if (clear) begin
            state_d     = IDLE;
            data_d      = '0;
            cnt_d       = '0;
            last_d      = 1'b0;
            full_d      = 1'b0;
            out_valid_d = 1'b0;
            tag_phase_d = 1'b0;
`ifdef ASCON_OUT_SKID_EN
            skid_d      = '0;
            skid_cnt_d  = '0;
            skid_last_d = 1'b0;
            skid_full_d = 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (s_fire) begin
                        data_d      = {s_tdata, 64'h0};
                        cnt_d       = nbytes;
                        last_d      = s_tlast;
                        full_d      = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = CT;
                    end else if (tag_tvalid) begin
                        state_d = WAIT_TAG;
                    end
                end
                CT: begin
                    if (ack) begin
                        if (cnt_q == 5'd1) begin
                            full_d      = 1'b0;
                            out_valid_d = 1'b0;
                            if (last_q) begin
                                state_d = WAIT_TAG;
                            end
`ifdef ASCON_OUT_SKID_EN
                            else if (skid_full_q) begin
                                data_d      = {skid_q, 64'h0};
                                cnt_d       = skid_cnt_q;
                                last_d      = skid_last_q;
                                full_d      = 1'b1;
                                out_valid_d = 1'b1;
                                skid_full_d = 1'b0;
                            end
`endif
                        end else begin
                            data_d = {data_q[119:0], 8'h00};
                            cnt_d  = cnt_q - 5'd1;
                        end
                    end
                    if (s_fire) begin
`ifdef ASCON_OUT_SKID_EN
                        if (full_d) begin
                            skid_d      = s_tdata;
                            skid_cnt_d  = nbytes;
                            skid_last_d = s_tlast;
                            skid_full_d = 1'b1;
                        end else begin
                            data_d      = {s_tdata, 64'h0};
                            cnt_d       = nbytes;
                            last_d      = s_tlast;
                            full_d      = 1'b1;
                            out_valid_d = 1'b1;
                        end
`else
                        data_d      = {s_tdata, 64'h0};
                        cnt_d       = nbytes;
                        last_d      = s_tlast;
                        full_d      = 1'b1;
                        out_valid_d = 1'b1;
`endif
                    end
                end
                WAIT_TAG: begin
                    if (t_fire) begin
                        data_d      = tag_tdata;
                        cnt_d       = 5'(TAG_BYTES);
                        last_d      = 1'b0;
                        out_valid_d = 1'b1;
                        tag_phase_d = 1'b1;
                        state_d     = TAG;
                    end
                end
                TAG: begin
                    if (ack) begin
                        if (cnt_q == 5'd1) begin
                            data_d      = '0;
                            cnt_d       = '0;
                            out_valid_d = 1'b0;
                            tag_phase_d = 1'b0;
                            state_d     = IDLE;
                        end else begin
                            data_d = {data_q[119:0], 8'h00};
                            cnt_d  = cnt_q - 5'd1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Handshake readies follow the next state and register occupancy.
    always_comb begin
`ifdef ASCON_OUT_SKID_EN
        s_tready_d = (state_d == IDLE || state_d == CT)
                     && !skid_full_d && !(full_d && last_d);
`else
        s_tready_d = (state_d == IDLE || state_d == CT) && !full_d;
`endif
        tag_tready_d = (state_d == WAIT_TAG);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            data_q       <= '0;
            cnt_q        <= '0;
            last_q       <= 1'b0;
            full_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            tag_phase_q  <= 1'b0;
            s_tready_q   <= 1'b0;
            tag_tready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            full_q       <= full_d;
            out_valid_q  <= out_valid_d;
            tag_phase_q  <= tag_phase_d;
            s_tready_q   <= s_tready_d;
            tag_tready_q <= tag_tready_d;
        end
    end

`ifdef ASCON_OUT_SKID_EN
    // Skid word register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q      <= '0;
            skid_cnt_q  <= '0;
            skid_last_q <= 1'b0;
            skid_full_q <= 1'b0;
        end else begin
            skid_q      <= skid_d;
            skid_cnt_q  <= skid_cnt_d;
            skid_last_q <= skid_last_d;
            skid_full_q <= skid_full_d;
        end
    end
`endif

    assign byte_out   = data_q[127:120];
    assign out_valid  = out_valid_q;
    assign tag_phase  = tag_phase_q;
    assign s_tready   = s_tready_q;
    assign tag_tready = tag_tready_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ascon_out_serializer.sv
// Directed scoreboard bench for ascon_out_serializer.
// Expected bytes are queued at stimulus time and popped on each ack.
module tb_ascon_out_serializer;

    localparam int TB = 16;

    logic         clk;
    logic         rst_n;
    logic         clear;
    logic [63:0]  s_tdata;
    logic         s_tvalid;
    logic         s_tready;
    logic         s_tlast;
    logic [3:0]   s_tbytes;
    logic [127:0] tag_tdata;
    logic         tag_tvalid;
    logic         tag_tready;
    logic [7:0]   byte_out;
    logic         out_valid;
    logic         read_ack;
    logic         busy;
    logic         tag_phase;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [8:0] exp_q[$];

    ascon_out_serializer #(.TAG_BYTES(TB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tlast    (s_tlast),
        .s_tbytes   (s_tbytes),
        .tag_tdata  (tag_tdata),
        .tag_tvalid (tag_tvalid),
        .tag_tready (tag_tready),
        .byte_out   (byte_out),
        .out_valid  (out_valid),
        .read_ack   (read_ack),
        .busy       (busy),
        .tag_phase  (tag_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        vec_cnt++;
        err_cnt++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    task automatic send_word(input logic [63:0] d, input logic [3:0] b,
                             input logic l);
        int nb;
        int w;
        nb = (b == 4'd0 || b > 4'd8) ? 8 : int'(b);
        for (int k = 0; k < nb; k++)
            exp_q.push_back({1'b0, d[63-8*k -: 8]});
        s_tdata  = d;
        s_tbytes = b;
        s_tlast  = l;
        s_tvalid = 1'b1;
        w = 0;
        while (!s_tready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!s_tready) timeout("s_hs");
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_tag(input logic [127:0] t);
        int w;
        for (int k = 0; k < TB; k++)
            exp_q.push_back({1'b1, t[127-8*k -: 8]});
        tag_tdata  = t;
        tag_tvalid = 1'b1;
        w = 0;
        while (!tag_tready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!tag_tready) timeout("tag_hs");
        @(negedge clk);
        tag_tvalid = 1'b0;
    endtask

    task automatic drain(input int n, input int gap_idx, output int gap);
        logic [8:0] e;
        int w;
        gap = -1;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (!out_valid && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (i == gap_idx) gap = w;
            if (!out_valid) begin
                timeout("out_valid");
                return;
            end
            if (exp_q.size() == 0) begin
                timeout("sb_empty");
                return;
            end
            e = exp_q.pop_front();
            check("byte", {120'h0, byte_out}, {120'h0, e[7:0]});
            check("tphase", {127'h0, tag_phase}, {127'h0, e[8]});
            read_ack = 1'b1;
            @(negedge clk);
            read_ack = 1'b0;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ov"}, {127'h0, out_valid}, 128'h0);
        check({tag, "_busy"}, {127'h0, busy}, 128'h0);
        check({tag, "_tp"}, {127'h0, tag_phase}, 128'h0);
    endtask

    initial begin
        int g;
        int exp_gap;
        logic [7:0] held;
        rst_n      = 1'b0;
        clear      = 1'b0;
        s_tdata    = '0;
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        s_tbytes   = 4'd0;
        tag_tdata  = '0;
        tag_tvalid = 1'b0;
        read_ack   = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_byte", {120'h0, byte_out}, 128'h0);
        check("rst_srdy", {127'h0, s_tready}, 128'h0);
        check("rst_trdy", {127'h0, tag_tready}, 128'h0);
        check_idle("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_srdy", {127'h0, s_tready}, 128'h1);

        // Single full word then tag.
        send_word(64'h1b0276e833b5bdc3, 4'd8, 1'b1);
        drain(8, -1, g);
        check("wait_trdy", {127'h0, tag_tready}, 128'h1);
        send_tag(128'h7964b9cac01116190a4ad52d9023ed19);
        drain(TB, -1, g);
        check_idle("w1_end");

        // Partial word: only three bytes, then waiting for the tag.
        send_word(64'hAABBCCDD00000000, 4'd3, 1'b1);
        drain(3, -1, g);
        repeat (2) @(negedge clk);
        check("part_ov", {127'h0, out_valid}, 128'h0);
        check("part_trdy", {127'h0, tag_tready}, 128'h1);
        check("part_busy", {127'h0, busy}, 128'h1);
        send_tag(128'h00112233445566778899aabbccddeeff);
        drain(TB, -1, g);
        check_idle("part_end");

        // Stall for ten cycles mid-word.
        send_word(64'h0123456789abcdef, 4'd8, 1'b1);
        drain(2, -1, g);
        held = exp_q[0][7:0];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_byte", {120'h0, byte_out}, {120'h0, held});
            check("stall_ov", {127'h0, out_valid}, 128'h1);
        end
        drain(6, -1, g);
        send_tag(128'hf0e1d2c3b4a5968778695a4b3c2d1e0f);
        drain(TB, -1, g);
        check_idle("stall_end");

        // Back-to-back words; second uses s_tbytes=0 meaning 8.
`ifdef ASCON_OUT_SKID_EN
        exp_gap = 0;
`else
        exp_gap = 1;
`endif
        fork
            begin
                send_word(64'h0011223344556677, 4'd8, 1'b0);
                send_word(64'h8899AABBCCDDEEFF, 4'd0, 1'b1);
            end
            drain(16, 8, g);
        join
        check("b2b_gap", 128'(g), 128'(exp_gap));
        send_tag(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
        drain(TB, -1, g);
        check_idle("b2b_end");

        // Empty message: tag request from IDLE.
        tag_tvalid = 1'b1;
        tag_tdata  = 128'h55aa55aa00ff00ff1234567890abcdef;
        #1;
        check("empty_trdy0", {127'h0, tag_tready}, 128'h0);
        tag_tvalid = 1'b0;
        send_tag(128'h55aa55aa00ff00ff1234567890abcdef);
        drain(TB, -1, g);
        check_idle("empty_end");

        // Clear after three bytes, colliding with an ack.
        send_word(64'hdeadbeefcafef00d, 4'd8, 1'b1);
        drain(3, -1, g);
        clear    = 1'b1;
        read_ack = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        read_ack = 1'b0;
        exp_q.delete();
        check_idle("clr");
        check("clr_byte", {120'h0, byte_out}, 128'h0);
        send_word(64'h1122334455667788, 4'd5, 1'b1);
        drain(5, -1, g);
        send_tag(128'h000102030405060708090a0b0c0d0e0f);
        drain(TB, -1, g);
        check_idle("clr_end");

        // Asynchronous reset in the middle of the tag.
        send_word(64'h0f0e0d0c0b0a0908, 4'd4, 1'b1);
        drain(4, -1, g);
        send_tag(128'hffeeddccbbaa99887766554433221100);
        drain(4, -1, g);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_byte", {120'h0, byte_out}, 128'h0);
        check("arst_srdy", {127'h0, s_tready}, 128'h0);
        check("arst_trdy", {127'h0, tag_tready}, 128'h0);
        check_idle("arst");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send_word(64'hc001d00dbeefface, 4'd9, 1'b1);
        drain(8, -1, g);
        send_tag(128'h13579bdf2468ace013579bdf2468ace0);
        drain(TB, -1, g);
        check_idle("arst_end");
        check("sb_left", 128'(exp_q.size()), 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ascon_out_serializer.md
ASCON_OUT_SERIALIZER -- requirements
Module: ascon_out_serializer

Interface
REQ-001 SHALL have parameter TAG_BYTES, default 16: number of tag bytes emitted, legal 8..16; the emitted bytes are the upper TAG_BYTES of tag_tdata.
REQ-002 SHALL have one clock; reset is asynchronous and active-low. Ports: clk in 1 (system clock); rst_n in 1 (async active-low reset).
REQ-003 SHALL have these ports:
- clear in 1: synchronous abort.
- s_tdata in 64: ciphertext word, byte 0 in [63:56].
- s_tvalid in 1: ciphertext word valid.
- s_tready out 1: ciphertext word accepted.
- s_tlast in 1: last ciphertext word of the message.
- s_tbytes in 4: valid bytes in the word, 1..8; 0 or >8 means 8.
- tag_tdata in 128: tag, byte 0 in [127:120].
- tag_tvalid in 1: tag valid.
- tag_tready out 1: tag accepted.
- byte_out out 8: current output byte.
- out_valid out 1: byte_out is valid.
- read_ack in 1: host consumed byte_out.
- busy out 1: state is not IDLE.
- tag_phase out 1: the byte being emitted is a tag byte.

Function
REQ-004 SHALL implement states IDLE, CT, WAIT_TAG, TAG.
REQ-005 Transfers: a ciphertext word transfers when s_tvalid && s_tready at posedge; a tag transfers when tag_tvalid && tag_tready at posedge.
REQ-006 s_tready SHALL be 1 only in IDLE or CT, and only while the holding register is empty.
REQ-007 tag_tready SHALL be 1 only in WAIT_TAG.
REQ-008 Word accept: IDLE->CT. The word and its byte count are loaded. out_valid=1 on the next cycle with byte_out equal to byte 0 (MSB first).
REQ-009 Byte advance: read_ack with out_valid=1 advances to the next byte on the following cycle. read_ack with out_valid=0 SHALL be ignored.
REQ-010 Byte count: exactly s_tbytes bytes SHALL be emitted per word; trailing bytes are never presented.
REQ-011 End of word: when the last byte of a word is acked, the holding register becomes empty; out_valid=0 on the next cycle unless a queued word exists (REQ-021).
REQ-012 When the last byte of an s_tlast word is acked: CT->WAIT_TAG.
REQ-013 Tag accept: WAIT_TAG->TAG, tag_phase=1, TAG_BYTES bytes emitted MSB first with the same ack rule.
REQ-014 When the final tag byte is acked: TAG->IDLE, out_valid=0, tag_phase=0 the next cycle.
REQ-015 Empty message: s_tlast=1 with s_tvalid=1 in IDLE and s_tbytes ignored is NOT supported; an empty message is signalled by tag_tvalid in IDLE, which SHALL take IDLE->WAIT_TAG. tag_tready stays 0 that cycle, so the tag transfers the following cycle.
REQ-016 clear=1 SHALL force IDLE, empty all registers, and drop out_valid next cycle. clear SHALL have priority over a simultaneous read_ack or accept.
REQ-017 Stall: byte_out and out_valid SHALL hold stable while out_valid=1 and read_ack=0.
REQ-018 busy SHALL be 0 only in IDLE.

Reset
REQ-019 rst_n=0 SHALL asynchronously force IDLE, all data registers to 0, byte_out=0, out_valid=0, s_tready=0, tag_tready=0, busy=0, tag_phase=0.
REQ-020 Reset deasserted mid-message SHALL discard all partial data; the first post-reset word starts a new message.

Configuration
REQ-021 Macro ASCON_OUT_SKID_EN:
- Defined: adds a second 64-bit word register (plus byte count and tlast). s_tready=1 in IDLE/CT whenever the skid is empty, including while a word drains. On the last-byte ack the skid word moves to the holding register and out_valid stays 1 with its byte 0 on the next cycle (zero bubble). An s_tlast word blocks further accepts.
- Undefined: single register; one bubble cycle between words.

Verification
REQ-022 Single word, then tag:
- Stimulus: s_tdata=64'h1b0276e833b5bdc3, s_tbytes=8, s_tlast=1; then tag 128'h7964b9cac01116190a4ad52d9023ed19; ack every out_valid.
- Required response: bytes 1b 02 76 e8 33 b5 bd c3 79 64 b9 ca c0 11 16 19 0a 4a d5 2d 90 23 ed 19 (24 acks), tag_phase=1 from the 9th byte, busy=0 after the last ack.
REQ-023 Partial word:
- Stimulus: s_tdata=64'hAABBCCDD00000000, s_tbytes=3, s_tlast=1.
- Required response: exactly AA BB CC, then WAIT_TAG.
REQ-024 Stall:
- Stimulus: hold read_ack=0 for 10 cycles.
- Required response: byte_out stable, no byte lost or duplicated.
REQ-025 Two back-to-back words 64'h0011223344556677, 64'h8899AABBCCDDEEFF:
- Skid build: out_valid continuously 1 across the boundary.
- Non-skid build: exactly one out_valid=0 cycle between 77 and 88.
REQ-026 Abort and reset:
- clear asserted after 3 acked bytes: out_valid=0 next cycle, busy=0.
- rst_n pulsed low mid-TAG: all outputs 0 immediately (asynchronously).
- A new word after either SHALL emit correctly from byte 0.
